// File: rtl/traffic_pkg.sv
// ============================================================================
//  Module      : traffic_pkg
//  Description : Light encoding shared by the traffic light controller and
//                its side-road sensor front end.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package traffic_pkg;

    // 2'b11 is never driven by the controller; consumers treat it as RED.
    typedef enum logic [1:0] {
        GREEN  = 2'b00,
        YELLOW = 2'b01,
        RED    = 2'b10
    } light_t;

    function automatic logic is_green(input logic [1:0] light);
        return light == GREEN;
    endfunction

    function automatic logic is_yellow(input logic [1:0] light);
        return light == YELLOW;
    endfunction

endpackage : traffic_pkg

`default_nettype wire

// File: rtl/sync_debounce.sv
// ============================================================================
//  Module      : sync_debounce
//  Description : Two-flop synchroniser plus presence FSM that qualifies
//                arrivals and departures on a bouncing loop-detector input.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic loop_raw_i,
    output logic present_o,
    output logic arrive_o
);

    localparam int               c_QW     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_QW-1:0]  c_DEB_Q  = c_QW'(DEBOUNCE_CYCLES);
    localparam logic [c_QW-1:0]  c_Q_ONE  = c_QW'(1);

    typedef enum logic [1:0] {
        ST_ABSENT  = 2'd0,
        ST_RISE_Q  = 2'd1,
        ST_PRESENT = 2'd2,
        ST_FALL_Q  = 2'd3
    } pres_state_t;

    logic            sync1_q;
    logic            sync2_q;
    pres_state_t     state_q;
    pres_state_t     state_d;
    logic [c_QW-1:0] q_q;
    logic [c_QW-1:0] q_d;
    logic            present_q;
    logic            present_d;
    logic            arrive_q;
    logic            arrive_d;

    logic            w_loop_s;
    logic [c_QW-1:0] w_q_inc;

    assign w_loop_s = sync2_q;
    assign w_q_inc  = q_q + c_Q_ONE;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            state_q   <= ST_ABSENT;
            q_q       <= '0;
            present_q <= 1'b0;
            arrive_q  <= 1'b0;
        end else begin
            sync1_q   <= loop_raw_i;
            sync2_q   <= sync1_q;
            state_q   <= state_d;
            q_q       <= q_d;
            present_q <= present_d;
            arrive_q  <= arrive_d;
        end
    end

    // Qualification counter q holds the number of consecutive agreeing
    // samples seen so far; a single disagreeing sample aborts the attempt.
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        case (state_q)
            ST_ABSENT: begin
                if (w_loop_s) begin
                    if (c_DEB_Q == c_Q_ONE) begin
                        state_d = ST_PRESENT;
                        q_d     = '0;
                    end else begin
                        state_d = ST_RISE_Q;
                        q_d     = c_Q_ONE;
                    end
                end
            end
            ST_RISE_Q: begin
                if (!w_loop_s) begin
                    state_d = ST_ABSENT;
                    q_d     = '0;
                end else if (w_q_inc == c_DEB_Q) begin
                    state_d = ST_PRESENT;
                    q_d     = '0;
                end else begin
                    q_d     = w_q_inc;
                end
            end
            ST_PRESENT: begin
                if (!w_loop_s) begin
                    if (c_DEB_Q == c_Q_ONE) begin
                        state_d = ST_ABSENT;
                        q_d     = '0;
                    end else begin
                        state_d = ST_FALL_Q;
                        q_d     = c_Q_ONE;
                    end
                end
            end
            ST_FALL_Q: begin
                if (w_loop_s) begin
                    state_d = ST_PRESENT;
                    q_d     = '0;
                end else if (w_q_inc == c_DEB_Q) begin
                    state_d = ST_ABSENT;
                    q_d     = '0;
                end else begin
                    q_d     = w_q_inc;
                end
            end
            default: begin
                state_d = ST_ABSENT;
                q_d     = '0;
            end
        endcase
    end

    // Arrival fires only on entry into PRESENT from the absent side, so a
    // rejected dropout (FALL_Q -> PRESENT) never produces a second pulse.
    always_comb begin
        present_d = (state_d == ST_PRESENT) || (state_d == ST_FALL_Q);
        arrive_d  = ((state_q == ST_ABSENT) || (state_q == ST_RISE_Q)) &&
                    (state_d == ST_PRESENT);
    end

    assign present_o = present_q;
    assign arrive_o  = arrive_q;

endmodule : sync_debounce

`default_nettype wire

// File: rtl/side_road_vehicle_detector.sv
// ============================================================================
//  Module      : side_road_vehicle_detector
//  Description : Debounced side-road vehicle detector that counts waiting
//                vehicles and raises the controller's sensor request.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module side_road_vehicle_detector
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             loop_raw,
    input  logic [1:0]       side,
    output logic             sensor,
    output logic             car_present,
    output logic             arrive,
    output logic [CNT_W-1:0] waiting_cnt
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    logic             w_deb_present;
    logic             w_deb_arrive;
    logic             w_served;

    logic [1:0]       side_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             sensor_q;
    logic             sensor_d;
    logic             present_q;
    logic             arrive_q;

    sync_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_sync_debounce (
        .clk        (clk),
        .reset      (reset),
        .loop_raw_i (loop_raw),
        .present_o  (w_deb_present),
        .arrive_o   (w_deb_arrive)
    );

    // The side road counts as served on the GREEN->YELLOW transition.
    assign w_served = is_green(side_q) && is_yellow(side);

    // A car qualifying on the service edge was not served, so it survives.
    always_comb begin
        cnt_d = cnt_q;
        if (w_served) begin
            cnt_d = w_deb_arrive ? c_CNT_ONE : '0;
        end else if (w_deb_arrive && (cnt_q != c_CNT_MAX)) begin
            cnt_d = cnt_q + c_CNT_ONE;
        end
    end

    always_comb begin
        sensor_d = (cnt_d != '0) || (w_deb_present && !is_green(side));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            side_q    <= RED;
            cnt_q     <= '0;
            sensor_q  <= 1'b0;
            present_q <= 1'b0;
            arrive_q  <= 1'b0;
        end else begin
            side_q    <= side;
            cnt_q     <= cnt_d;
            sensor_q  <= sensor_d;
            present_q <= w_deb_present;
            arrive_q  <= w_deb_arrive;
        end
    end

    assign sensor      = sensor_q;
    assign car_present = present_q;
    assign arrive      = arrive_q;
    assign waiting_cnt = cnt_q;

endmodule : side_road_vehicle_detector

`default_nettype wire
